// File: rtl/vga_draw_pkg.sv
// Shared definitions for the VGA drawing blocks: FSM encoding, draw modes
// and default screen geometry.
package vga_draw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } fill_state_e;

    localparam logic MODE_SOLID   = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/raster_scan_counter.sv
// Two-dimensional raster counter: cx sweeps 0..w-1, then wraps and bumps cy.
// last flags the final position (w-1, h-1).
module raster_scan_counter #(
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    output logic [DIM_W-1:0] cx,
    output logic [DIM_W-1:0] cy,
    output logic             last
);

    logic [DIM_W-1:0] cx_q, cx_d;
    logic [DIM_W-1:0] cy_q, cy_d;
    logic             x_end, y_end;

    assign x_end = (cx_q == (w - DIM_W'(1)));
    assign y_end = (cy_q == (h - DIM_W'(1)));

    // next position in raster order; load restarts at the origin
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en) begin
            if (x_end) begin
                cx_d = '0;
                if (y_end) begin
                    cy_d = '0;
                end else begin
                    cy_d = cy_q + DIM_W'(1);
                end
            end else begin
                cx_d = cx_q + DIM_W'(1);
                cy_d = cy_q;
            end
        end else begin
            cx_d = cx_q;
            cy_d = cy_q;
        end
    end

    // counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = x_end & y_end;

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle painter: latches a rectangle on start and raster-scans it one
// position per cycle, emitting clipped solid or outline pixels.
module rect_fill_engine
    import vga_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int DIM_W    = 8,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [DIM_W-1:0] rect_w,
    input  logic [DIM_W-1:0] rect_h,
    input  logic [COL_W-1:0] colour_in,
    input  logic             mode,
    input  logic             pause,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    // sums are wide enough that origin + offset can never wrap
    localparam int SX_W = max_int(X_W, DIM_W) + 1;
    localparam int SY_W = max_int(Y_W, DIM_W) + 1;
    localparam logic [SX_W-1:0] SCR_W_L = SX_W'(SCREEN_W);
    localparam logic [SY_W-1:0] SCR_H_L = SY_W'(SCREEN_H);

    fill_state_e      state_q;
    logic [X_W-1:0]   x0_q;
    logic [Y_W-1:0]   y0_q;
    logic [DIM_W-1:0] w_q;
    logic [DIM_W-1:0] h_q;
    logic             mode_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [COL_W-1:0] colour_q;
    logic             plot_q;
    logic             busy_q;
    logic             done_q;

    logic [DIM_W-1:0] cx, cy;
    logic             last;
    logic             start_ok;
    logic             size_zero;
    logic             scan_en;
    logic [SX_W-1:0]  sum_x;
    logic [SY_W-1:0]  sum_y;
    logic             in_screen;
    logic             on_border;
    logic             plot_d;

    assign start_ok  = (state_q == ST_IDLE) & start;
    assign size_zero = (rect_w == '0) | (rect_h == '0);
    assign scan_en   = (state_q == ST_RUN) & ~pause;

    raster_scan_counter #(
        .DIM_W (DIM_W)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok),
        .en    (scan_en),
        .w     (w_q),
        .h     (h_q),
        .cx    (cx),
        .cy    (cy),
        .last  (last)
    );

    assign sum_x = SX_W'(x0_q) + SX_W'(cx);
    assign sum_y = SY_W'(y0_q) + SY_W'(cy);

    // clip and outline qualification of the current scan position
    always_comb begin
        in_screen = 1'b0;
        on_border = 1'b0;
        plot_d    = 1'b0;
        in_screen = (sum_x < SCR_W_L) & (sum_y < SCR_H_L);
        on_border = (cx == '0) | (cx == (w_q - DIM_W'(1))) |
                    (cy == '0) | (cy == (h_q - DIM_W'(1)));
        if (in_screen && ((mode_q == MODE_SOLID) || on_border)) begin
            plot_d = 1'b1;
        end else begin
            plot_d = 1'b0;
        end
    end

    // control FSM, parameter latches and registered pixel outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            mode_q   <= MODE_SOLID;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        x0_q     <= x0;
                        y0_q     <= y0;
                        w_q      <= rect_w;
                        h_q      <= rect_h;
                        mode_q   <= mode;
                        colour_q <= colour_in;
                        busy_q   <= 1'b1;
                        state_q  <= size_zero ? ST_FIN : ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    done_q <= 1'b0;
                    if (pause) begin
                        plot_q <= 1'b0;
                    end else begin
                        x_q    <= sum_x[X_W-1:0];
                        y_q    <= sum_y[Y_W-1:0];
                        plot_q <= plot_d;
                        if (last) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_FIN: begin
                    plot_q  <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
